// File: rtl/pea_pkg.sv
// pea_pkg: shared PE-array control-word width, NOP encoding and sequencer state type.
package pea_pkg;
    localparam int N_CFG_BITS_PE = 16;
    localparam logic [N_CFG_BITS_PE-1:0] CTRL_NOP = '0;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} seq_state_t;
endpackage

// File: rtl/dae_ctx_mem.sv
// dae_ctx_mem: N_PE x N_CTX control-word register file, one write port, one N_PE-wide read at a shared ctx.
module dae_ctx_mem
    import pea_pkg::*;
#(
    parameter int N_PE  = 16,
    parameter int N_CTX = 4
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    we_i,
    input  logic [$clog2(N_PE)-1:0]                 pe_i,
    input  logic [$clog2(N_CTX)-1:0]                wctx_i,
    input  logic [N_CFG_BITS_PE-1:0]                word_i,
    input  logic [$clog2(N_CTX)-1:0]                rctx_i,
    output logic [N_PE-1:0][N_CFG_BITS_PE-1:0]      rd_o
);
    localparam int PW = $clog2(N_PE);
    logic [N_PE-1:0][N_CTX-1:0][N_CFG_BITS_PE-1:0] r_mem;
    always_ff @(posedge clk_i) begin
        if (rst_i) r_mem <= {(N_PE*N_CTX){CTRL_NOP}};
        else if (we_i) r_mem[pe_i][wctx_i] <= word_i;
    end
    // Forward a same-cycle write so a run started alongside it sees the new word.
    for (genvar p = 0; p < N_PE; p++) begin : g_rd
        assign rd_o[p] = (we_i && pe_i == PW'(p) && wctx_i == rctx_i) ? word_i : r_mem[p][rctx_i];
    end
endmodule

// File: rtl/dae_pe_ctx_sequencer.sv
// dae_pe_ctx_sequencer: replays stored per-PE contexts for n_iter iterations, then drains with NOPs.
// Optional macro DAE_SEQ_PERF_EN adds busy-cycle and stall-cycle performance counters.
module dae_pe_ctx_sequencer
    import pea_pkg::*;
#(
    parameter int N_PE       = 16,
    parameter int N_CTX      = 4,
    parameter int PIPE_DEPTH = 2,
    parameter int ITER_W     = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                cfg_we_i,
    input  logic [$clog2(N_PE)-1:0]             cfg_pe_i,
    input  logic [$clog2(N_CTX)-1:0]            cfg_ctx_i,
    input  logic [N_CFG_BITS_PE-1:0]            cfg_word_i,
    input  logic                                start_i,
    input  logic [$clog2(N_CTX):0]              n_ctx_i,
    input  logic [ITER_W-1:0]                   n_iter_i,
    input  logic                                stall_i,
    output logic [N_PE-1:0][N_CFG_BITS_PE-1:0]  ctrl_pe_o,
    output logic [$clog2(N_CTX)-1:0]            ctx_idx_o,
    output logic                                busy_o,
    output logic                                done_o,
    output logic                                cfg_err_o
`ifdef DAE_SEQ_PERF_EN
    ,
    output logic [31:0]                         perf_cycles_o,
    output logic [31:0]                         perf_stalls_o
`endif
);
    localparam int CW = $clog2(N_CTX);
    localparam int DW = $clog2(PIPE_DEPTH) + 1;
    seq_state_t r_state;
    logic [CW-1:0] r_ctx, r_nctx_m1, w_ctx_nxt, w_rd_ctx;
    logic [ITER_W-1:0] r_iter, r_niter_m1;
    logic [DW-1:0] r_drain;
    logic [N_PE-1:0][N_CFG_BITS_PE-1:0] r_ctrl, w_rd;
    logic r_busy, r_done, r_err;
    logic w_idle, w_start_ok, w_accept, w_wrap, w_last, w_we;

    assign w_idle     = r_state == IDLE;
    assign w_start_ok = n_ctx_i != '0 && n_ctx_i <= (CW+1)'(N_CTX) && n_iter_i != '0;
    assign w_accept   = w_idle && start_i && w_start_ok;
    assign w_wrap     = r_ctx == r_nctx_m1;
    assign w_last     = w_wrap && r_iter == r_niter_m1;
    assign w_ctx_nxt  = w_wrap ? '0 : r_ctx + CW'(1);
    assign w_rd_ctx   = r_state == RUN ? w_ctx_nxt : '0;
    assign w_we       = cfg_we_i && w_idle;

    dae_ctx_mem #(.N_PE(N_PE), .N_CTX(N_CTX)) u_mem (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .we_i   (w_we),
        .pe_i   (cfg_pe_i),
        .wctx_i (cfg_ctx_i),
        .word_i (cfg_word_i),
        .rctx_i (w_rd_ctx),
        .rd_o   (w_rd)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_ctx      <= '0;
            r_iter     <= '0;
            r_drain    <= '0;
            r_nctx_m1  <= '0;
            r_niter_m1 <= '0;
            r_ctrl     <= {N_PE{CTRL_NOP}};
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= (cfg_we_i && !w_idle) || (w_idle && start_i && !w_start_ok);
            case (r_state)
                IDLE: if (w_accept) begin
                    r_state    <= RUN;
                    r_ctx      <= '0;
                    r_iter     <= '0;
                    r_nctx_m1  <= CW'(n_ctx_i - (CW+1)'(1));
                    r_niter_m1 <= n_iter_i - ITER_W'(1);
                    r_ctrl     <= w_rd;
                    r_busy     <= 1'b1;
                end
                RUN: if (!stall_i) begin
                    if (w_last) begin
                        r_state <= DRAIN;
                        r_ctx   <= '0;
                        r_drain <= '0;
                        r_ctrl  <= {N_PE{CTRL_NOP}};
                    end else begin
                        r_ctx  <= w_ctx_nxt;
                        r_ctrl <= w_rd;
                        if (w_wrap) r_iter <= r_iter + ITER_W'(1);
                    end
                end
                DRAIN: if (!stall_i) begin
                    if (r_drain == DW'(PIPE_DEPTH - 1)) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= r_drain + DW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ctrl_pe_o = r_ctrl;
    assign ctx_idx_o = r_ctx;
    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign cfg_err_o = r_err;

`ifdef DAE_SEQ_PERF_EN
    logic [31:0] r_cyc, r_stl;
    always_ff @(posedge clk_i) begin
        if (rst_i || w_accept) begin
            r_cyc <= '0;
            r_stl <= '0;
        end else begin
            if (r_busy && ~&r_cyc) r_cyc <= r_cyc + 32'd1;
            if (r_busy && stall_i && ~&r_stl) r_stl <= r_stl + 32'd1;
        end
    end
    assign perf_cycles_o = r_cyc;
    assign perf_stalls_o = r_stl;
`endif
endmodule

// File: tb/tb_dae_pe_ctx_sequencer.sv
// tb_dae_pe_ctx_sequencer: vector table with scoreboard queue, plus a long single-context run.
module tb_dae_pe_ctx_sequencer;
    import pea_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, cfg_we, start, stall;
    logic [3:0] cfg_pe;
    logic [1:0] cfg_ctx;
    logic [N_CFG_BITS_PE-1:0] cfg_word;
    logic [2:0] n_ctx;
    logic [15:0] n_iter;
    logic [15:0][N_CFG_BITS_PE-1:0] ctrl_pe;
    logic [1:0] ctx_idx;
    logic busy, done, cfg_err;
`ifdef DAE_SEQ_PERF_EN
    logic [31:0] perf_cycles, perf_stalls;
`endif

    dae_pe_ctx_sequencer dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cfg_we_i   (cfg_we),
        .cfg_pe_i   (cfg_pe),
        .cfg_ctx_i  (cfg_ctx),
        .cfg_word_i (cfg_word),
        .start_i    (start),
        .n_ctx_i    (n_ctx),
        .n_iter_i   (n_iter),
        .stall_i    (stall),
        .ctrl_pe_o  (ctrl_pe),
        .ctx_idx_o  (ctx_idx),
        .busy_o     (busy),
        .done_o     (done),
        .cfg_err_o  (cfg_err)
`ifdef DAE_SEQ_PERF_EN
        ,
        .perf_cycles_o (perf_cycles),
        .perf_stalls_o (perf_stalls)
`endif
    );

    typedef struct {
        logic we; logic [1:0] wctx; logic [15:0] word;
        logic st; logic [2:0] nctx; logic [15:0] niter; logic stall; logic rst;
    } in_t;
    typedef struct {
        logic [15:0] ctrl3; logic [1:0] ctx; logic busy, done, err;
    } exp_t;
    typedef struct { in_t i; exp_t e; } vec_t;

    vec_t tv[80];
    int n_vec = 0;
    exp_t sb[$];
    int n_checks = 0, n_err = 0, cur_step = 0;

    function automatic void add(input logic we, input logic [1:0] wctx, input logic [15:0] word,
                                input logic st, input logic [2:0] nctx, input logic [15:0] niter,
                                input logic stl, input logic rs, input logic [15:0] ec,
                                input logic [1:0] ex, input logic eb, input logic ed, input logic ee);
        tv[n_vec].i = '{we, wctx, word, st, nctx, niter, stl, rs};
        tv[n_vec].e = '{ec, ex, eb, ed, ee};
        n_vec++;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, cur_step, act, exp);
        end
    endtask

    task automatic drive(input in_t v);
        rst = v.rst; cfg_we = v.we; cfg_pe = 4'd3; cfg_ctx = v.wctx; cfg_word = v.word;
        start = v.st; n_ctx = v.nctx; n_iter = v.niter; stall = v.stall;
    endtask

    task automatic idle_inputs();
        rst = 0; cfg_we = 0; cfg_pe = 0; cfg_ctx = 0; cfg_word = 0;
        start = 0; n_ctx = 0; n_iter = 0; stall = 0;
    endtask

    initial begin
        exp_t e;
        logic [15:0][N_CFG_BITS_PE-1:0] oth;
        int busy_n;
        bit got_done;
        idle_inputs();
        // we wctx word st nctx niter stall rst | ctrl3 ctx busy done err
        add(0,0,'h00,0,0,0,0,1, 'h00,0,0,0,0);
        add(1,0,'h11,0,0,0,0,0, 'h00,0,0,0,0);
        add(1,1,'h22,0,0,0,0,0, 'h00,0,0,0,0);
        add(1,2,'h33,0,0,0,0,0, 'h00,0,0,0,0);
        add(1,3,'h44,0,0,0,0,0, 'h00,0,0,0,0);
        add(0,0,'h00,1,4,2,0,0, 'h11,0,1,0,0);
        add(0,0,'h00,0,0,0,0,0, 'h22,1,1,0,0);
        add(0,0,'h00,0,0,0,0,0, 'h33,2,1,0,0);
        add(0,0,'h00,0,0,0,0,0, 'h44,3,1,0,0);
        add(0,0,'h00,0,0,0,0,0, 'h11,0,1,0,0);
        add(0,0,'h00,0,0,0,0,0, 'h22,1,1,0,0);
        add(0,0,'h00,0,0,0,0,0, 'h33,2,1,0,0);
        add(0,0,'h00,0,0,0,0,0, 'h44,3,1,0,0);
        add(0,0,'h00,0,0,0,0,0, 'h00,0,1,0,0);
        add(0,0,'h00,0,0,0,0,0, 'h00,0,1,0,0);
        add(0,0,'h00,0,0,0,0,0, 'h00,0,0,1,0);
        add(0,0,'h00,0,0,0,1,0, 'h00,0,0,0,0);
        // stalled replay
        add(0,0,'h00,1,4,2,0,0, 'h11,0,1,0,0);
        add(0,0,'h00,0,0,0,0,0, 'h22,1,1,0,0);
        add(0,0,'h00,0,0,0,0,0, 'h33,2,1,0,0);
        add(0,0,'h00,0,0,0,1,0, 'h33,2,1,0,0);
        add(0,0,'h00,0,0,0,1,0, 'h33,2,1,0,0);
        add(0,0,'h00,0,0,0,1,0, 'h33,2,1,0,0);
        add(0,0,'h00,0,0,0,0,0, 'h44,3,1,0,0);
        add(0,0,'h00,0,0,0,0,0, 'h11,0,1,0,0);
        add(0,0,'h00,0,0,0,0,0, 'h22,1,1,0,0);
        add(0,0,'h00,0,0,0,0,0, 'h33,2,1,0,0);
        add(0,0,'h00,0,0,0,0,0, 'h44,3,1,0,0);
        add(0,0,'h00,0,0,0,0,0, 'h00,0,1,0,0);
        add(0,0,'h00,0,0,0,0,0, 'h00,0,1,0,0);
        add(0,0,'h00,0,0,0,0,0, 'h00,0,0,1,0);
        // invalid starts
        add(0,0,'h00,1,0,5,0,0, 'h00,0,0,0,1);
        add(0,0,'h00,0,0,0,0,0, 'h00,0,0,0,0);
        add(0,0,'h00,1,4,0,0,0, 'h00,0,0,0,1);
        add(0,0,'h00,0,0,0,0,0, 'h00,0,0,0,0);
        add(0,0,'h00,1,5,1,0,0, 'h00,0,0,0,1);
        add(0,0,'h00,0,0,0,0,0, 'h00,0,0,0,0);
        // write to live slot during run, start during run ignored
        add(0,0,'h00,1,1,3,0,0, 'h11,0,1,0,0);
        add(1,0,'hEE,0,0,0,0,0, 'h11,0,1,0,1);
        add(0,0,'h00,1,0,0,0,0, 'h11,0,1,0,0);
        add(0,0,'h00,0,0,0,0,0, 'h00,0,1,0,0);
        add(0,0,'h00,0,0,0,0,0, 'h00,0,1,0,0);
        add(0,0,'h00,0,0,0,0,0, 'h00,0,0,1,0);
        add(0,0,'h00,1,1,1,0,0, 'h11,0,1,0,0);
        add(0,0,'h00,0,0,0,0,0, 'h00,0,1,0,0);
        add(0,0,'h00,0,0,0,0,0, 'h00,0,1,0,0);
        add(0,0,'h00,0,0,0,0,0, 'h00,0,0,1,0);
        // write and start in the same cycle
        add(1,0,'h66,1,2,1,0,0, 'h66,0,1,0,0);
        add(0,0,'h00,0,0,0,0,0, 'h22,1,1,0,0);
        add(0,0,'h00,0,0,0,0,0, 'h00,0,1,0,0);
        add(0,0,'h00,0,0,0,0,0, 'h00,0,1,0,0);
        add(0,0,'h00,0,0,0,0,0, 'h00,0,0,1,0);
        // reset mid-run, then readback of cleared memory
        add(0,0,'h00,1,4,4,0,0, 'h66,0,1,0,0);
        add(0,0,'h00,0,0,0,0,0, 'h22,1,1,0,0);
        add(0,0,'h00,0,0,0,0,0, 'h33,2,1,0,0);
        add(0,0,'h00,0,0,0,0,0, 'h44,3,1,0,0);
        add(0,0,'h00,0,0,0,0,1, 'h00,0,0,0,0);
        add(0,0,'h00,0,0,0,0,0, 'h00,0,0,0,0);
        add(0,0,'h00,1,4,1,0,0, 'h00,0,1,0,0);
        add(0,0,'h00,0,0,0,0,0, 'h00,1,1,0,0);
        add(0,0,'h00,0,0,0,0,0, 'h00,2,1,0,0);
        add(0,0,'h00,0,0,0,0,0, 'h00,3,1,0,0);
        add(0,0,'h00,0,0,0,0,0, 'h00,0,1,0,0);
        add(0,0,'h00,0,0,0,0,0, 'h00,0,1,0,0);
        add(0,0,'h00,0,0,0,0,0, 'h00,0,0,1,0);
        add(0,0,'h00,0,0,0,0,0, 'h00,0,0,0,0);

        for (int i = 0; i < n_vec; i++) begin
            cur_step = i;
            drive(tv[i].i);
            sb.push_back(tv[i].e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk("ctrl_pe3", 32'(ctrl_pe[3]), 32'(e.ctrl3));
            chk("ctx_idx", 32'(ctx_idx), 32'(e.ctx));
            chk("busy", 32'(busy), 32'(e.busy));
            chk("done", 32'(done), 32'(e.done));
            chk("cfg_err", 32'(cfg_err), 32'(e.err));
            oth = ctrl_pe;
            oth[3] = '0;
            chk("other_pes_zero", 32'(|oth), 32'd0);
`ifdef DAE_SEQ_PERF_EN
            if (i == 16) begin
                chk("perf_cycles_a", perf_cycles, 32'd10);
                chk("perf_stalls_a", perf_stalls, 32'd0);
            end
            if (i == 30 || i == 31) begin
                chk("perf_cycles_b", perf_cycles, 32'd13);
                chk("perf_stalls_b", perf_stalls, 32'd3);
            end
`endif
        end

        // single context, maximum iteration count
        cur_step = n_vec;
        idle_inputs();
        start = 1; n_ctx = 3'd1; n_iter = 16'hFFFF;
        @(posedge clk);
        #1;
        idle_inputs();
        busy_n = 0;
        got_done = 0;
        for (int c = 0; c < 70000 && !got_done; c++) begin
            if (busy) busy_n++;
            if (done) got_done = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("long_done_seen", 32'(got_done), 32'd1);
        chk("long_busy_cycles", 32'(busy_n), 32'd65537);
        chk("long_busy_after", 32'(busy), 32'd0);
`ifdef DAE_SEQ_PERF_EN
        chk("long_perf_cycles", perf_cycles, 32'd65537);
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/dae_pe_ctx_sequencer.md
# dae_pe_ctx_sequencer

Context sequencer for the decoupled access-execute Processing Element Array. Stores up to N_CTX control-word contexts per PE and replays them cycle by cycle into the PE array's per-PE control inputs for a programmed number of iterations. It handles stall, pipeline drain and completion signalling. It sits between the configuration bus and the `ctrl_pe_i` inputs of every PE in the array.

## Interface
- N_PE, 16, number of PEs driven
- N_CTX, 4, contexts stored per PE (power of two)
- PIPE_DEPTH, 2, drain cycles after the last context (PE FU plus output register)
- ITER_W, 16, width of the iteration count
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- cfg_we_i  in  1  context-memory write strobe
- cfg_pe_i  in  $clog2(N_PE)  target PE of the write
- cfg_ctx_i  in  $clog2(N_CTX)  target context slot of the write
- cfg_word_i  in  N_CFG_BITS_PE  control word to store
- start_i  in  1  start request, level-sampled in IDLE
- n_ctx_i  in  $clog2(N_CTX)+1  active contexts, valid range 1..N_CTX
- n_iter_i  in  ITER_W  iterations, valid range 1..2^ITER_W-1
- stall_i  in  1  backpressure from access side; freezes sequencing
- ctrl_pe_o  out  N_PE x N_CFG_BITS_PE  registered control word per PE
- ctx_idx_o  out  $clog2(N_CTX)  context currently driven
- busy_o  out  1  high in RUN and DRAIN
- done_o  out  1  one-cycle pulse at completion
- cfg_err_o  out  1  one-cycle pulse on a rejected write or start

## Operation
- Context memory: N_PE x N_CTX words, cleared to 0 on reset. Word 0 is the NOP encoding (fu_instr NOP, mux selects 0, vec_mode 0).
- Writes are accepted only in IDLE. A write in RUN or DRAIN is dropped and cfg_err_o pulses.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN: start_i=1 with n_ctx_i in 1..N_CTX and n_iter_i != 0. n_ctx_i and n_iter_i are latched on this edge.
  - start_i with invalid n_ctx_i or n_iter_i: the FSM stays in IDLE and cfg_err_o pulses.
  - start_i in RUN or DRAIN is ignored and does not raise cfg_err_o.
  - RUN: each non-stalled cycle advances ctx. When ctx reaches n_ctx-1, it wraps to 0 and the iteration counter increments.
  - RUN -> DRAIN: after the last context of the last iteration has been driven for one non-stalled cycle.
  - DRAIN: ctrl_pe_o = 0 (NOP) for PIPE_DEPTH non-stalled cycles. Then the FSM goes to IDLE and done_o pulses on that transition.
- stall_i=1 in RUN or DRAIN holds the state, counters and ctrl_pe_o. stall_i is ignored in IDLE.
- ctrl_pe_o[p] is the memory word [p][ctx], registered. In IDLE the output is all zeros.
- Counters are unsigned. The iteration counter compares against the latched n_iter-1, so there is no overflow at n_iter = 2^ITER_W-1.

## Timing
- Reset values: ctrl_pe_o=0, ctx_idx_o=0, busy_o=0, done_o=0, cfg_err_o=0, FSM in IDLE, memory cleared.
- rst_i asserted mid-run: on the next edge all outputs return to reset values and the run is abandoned without a done_o pulse.
- Start at edge T: at T+1, ctrl_pe_o holds ctx 0 and busy_o=1.
- With no stalls, a run spans n_ctx*n_iter + PIPE_DEPTH cycles of busy_o. done_o is high on the cycle busy_o falls.
- Write at edge T with start at T+1: the written word is used by that run.
- A write and a start in the same IDLE cycle: the write completes first, and the run uses the new word.
- cfg_err_o is registered and appears one cycle after the offending request.

## Configuration
- DAE_SEQ_PERF_EN defined: adds outputs perf_cycles_o (32 bits, counts busy cycles) and perf_stalls_o (32 bits, counts busy cycles with stall_i=1).
  - Both clear on a start accept and on reset, saturate at all-ones, and hold after done_o.
- DAE_SEQ_PERF_EN undefined: the ports and counters do not exist.

## Structure
- Shared package pea_pkg holds:
  - N_CFG_BITS_PE
  - the NOP control-word constant
  - the FSM state enum seq_state_t (IDLE, RUN, DRAIN)
- One natural sub-module, dae_ctx_mem: the N_PE x N_CTX register file with a single write port and one N_PE-wide read at a shared ctx index.
- The FSM and counters stay in the top module.

## Test plan
- Write PE 3 ctx 0..3 = 0x11,0x22,0x33,0x44. Start with n_ctx=4, n_iter=2, no stall. Expected:
  - ctrl_pe_o[3] = 11,22,33,44,11,22,33,44,0,0
  - done_o on cycle 10
  - busy_o high for 10 cycles
- Same run with stall_i=1 on cycles 3-5. Expected:
  - ctrl_pe_o[3] holds 0x33 for 3 extra cycles
  - done_o delayed by 3 cycles
  - perf_stalls_o=3 with DAE_SEQ_PERF_EN
- start with n_ctx=0, then start with n_iter=0. Expected: cfg_err_o pulses each time and busy_o stays 0.
- cfg_we_i during RUN targeting the live slot. Expected: cfg_err_o pulses, and the replayed word is unchanged in this run and later runs.
- rst_i asserted at cycle 4 of a 16-cycle run. Expected: next cycle has all outputs 0, no done_o, and a readback run shows the memory cleared.
- n_ctx=1, n_iter=65535. Expected: done_o after 65537 busy cycles, with no counter wrap.
